// File: rtl/chroma_key_ctrl.sv
// chroma_key_ctrl: frame-synchronous keyer settings, background address generation and keyed-pixel stats.
// Define CHROMA_IRQ_EN to build IRQ_EN, IRQ_PEND and the end-of-frame interrupt.
module chroma_key_ctrl #(
    parameter int         H_ACTIVE    = 640,
    parameter int         V_ACTIVE    = 480,
    parameter int         ADDR_W      = 19,
    parameter logic [9:0] DEFAULT_THR = 10'h1FF
) (
    input  logic              iCLK27,
    input  logic              iRST,
    input  logic [2:0]        iAddr,
    input  logic              iWrite,
    input  logic [31:0]       iWriteData,
    input  logic              iRead,
    output logic [31:0]       oReadData,
    input  logic              iSOF,
    input  logic              iPixValid,
    input  logic              iIsKeyed,
    output logic [9:0]        oThreshold,
    output logic              oKeyEn,
    output logic [ADDR_W-1:0] oBgAddr,
    output logic              oIrq
);
    localparam int NPIX = H_ACTIVE * V_ACTIVE;
    localparam int CW   = $clog2(NPIX + 1);

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;
    state_t state_q, state_d;

    logic              en_q, en_d;
    logic [9:0]        thr_q, thr_d, sh_thr_q, sh_thr_d;
    logic [ADDR_W-1:0] base_q, base_d, sh_base_q, sh_base_d, bg_q, bg_d;
    logic [CW-1:0]     pix_q, pix_d;
    logic [19:0]       run_q, run_d, kc_q, kc_d;
    logic [15:0]       fc_q, fc_d;
    logic              ovr_q, ovr_d;
    logic [31:0]       rd_q, rd_d, rd_mux;
    logic              key_en, load, close, pix_ok, full, w1c, irq_en_v, pend_v;
    logic              unused_wdata;

    assign unused_wdata = ^iWriteData[31:ADDR_W];

    always_ff @(posedge iCLK27 or posedge iRST) begin
        if (iRST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en_q) state_d = ARMED;
            ARMED:   if (iSOF) state_d = ACTIVE; else if (!en_q) state_d = IDLE;
            ACTIVE:  if (iSOF && !en_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        key_en = state_q == ACTIVE;
        load   = iSOF && state_q != IDLE;
        close  = iSOF && state_q == ACTIVE;
    end

    // A pixel coinciding with iSOF belongs to no frame and is dropped.
    always_comb begin
        w1c       = iWrite && iAddr == 3'd3;
        pix_ok    = iPixValid && !iSOF;
        full      = pix_q == CW'(NPIX);
        en_d      = (iWrite && iAddr == 3'd0) ? iWriteData[0] : en_q;
        thr_d     = (iWrite && iAddr == 3'd1) ? iWriteData[9:0] : thr_q;
        base_d    = (iWrite && iAddr == 3'd2) ? iWriteData[ADDR_W-1:0] : base_q;
        sh_thr_d  = load ? thr_q : sh_thr_q;
        sh_base_d = load ? base_q : sh_base_q;
        pix_d     = iSOF ? '0 : (pix_ok && !full) ? pix_q + 1'b1 : pix_q;
        bg_d      = sh_base_d + ADDR_W'(pix_d);
        ovr_d     = (pix_ok && full) || (ovr_q && !(w1c && iWriteData[2]));
        run_d     = iSOF ? '0 : (pix_ok && iIsKeyed && key_en && run_q != '1) ? run_q + 1'b1 : run_q;
        kc_d      = close ? run_q : kc_q;
        fc_d      = close ? fc_q + 1'b1 : fc_q;
    end

    always_comb begin
        rd_mux = '0;
        case (iAddr)
            3'd0: rd_mux = {30'd0, irq_en_v, en_q};
            3'd1: rd_mux = {22'd0, thr_q};
            3'd2: rd_mux = 32'(base_q);
            3'd3: rd_mux = {29'd0, ovr_q, pend_v, key_en};
            3'd4: rd_mux = 32'(kc_q);
            3'd5: rd_mux = 32'(fc_q);
            default: rd_mux = '0;
        endcase
        rd_d = iRead ? rd_mux : '0;
    end

    always_ff @(posedge iCLK27 or posedge iRST) begin
        if (iRST) begin
            en_q      <= 1'b0;
            thr_q     <= DEFAULT_THR;
            base_q    <= '0;
            sh_thr_q  <= DEFAULT_THR;
            sh_base_q <= '0;
            bg_q      <= '0;
            pix_q     <= '0;
            run_q     <= '0;
            kc_q      <= '0;
            fc_q      <= '0;
            ovr_q     <= 1'b0;
            rd_q      <= '0;
        end else begin
            en_q      <= en_d;
            thr_q     <= thr_d;
            base_q    <= base_d;
            sh_thr_q  <= sh_thr_d;
            sh_base_q <= sh_base_d;
            bg_q      <= bg_d;
            pix_q     <= pix_d;
            run_q     <= run_d;
            kc_q      <= kc_d;
            fc_q      <= fc_d;
            ovr_q     <= ovr_d;
            rd_q      <= rd_d;
        end
    end

`ifdef CHROMA_IRQ_EN
    logic irq_en_q, irq_en_d, pend_q, pend_d, irq_q;

    // A frame close outranks a simultaneous write-1-to-clear.
    always_comb begin
        irq_en_d = (iWrite && iAddr == 3'd0) ? iWriteData[1] : irq_en_q;
        pend_d   = close || (pend_q && !(w1c && iWriteData[1]));
    end

    always_ff @(posedge iCLK27 or posedge iRST) begin
        if (iRST) begin
            irq_en_q <= 1'b0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            pend_q   <= pend_d;
            irq_q    <= pend_d && irq_en_d;
        end
    end

    assign irq_en_v = irq_en_q;
    assign pend_v   = pend_q;
    assign oIrq     = irq_q;
`else
    assign irq_en_v = 1'b0;
    assign pend_v   = 1'b0;
    assign oIrq     = 1'b0;
`endif

    assign oReadData  = rd_q;
    assign oThreshold = sh_thr_q;
    assign oKeyEn     = key_en;
    assign oBgAddr    = bg_q;
endmodule

// File: tb/tb_chroma_key_ctrl.sv
// tb_chroma_key_ctrl: directed checks of chroma_key_ctrl on a reduced 8x4 frame.
module tb_chroma_key_ctrl;
`ifdef CHROMA_IRQ_EN
    localparam logic IRQ = 1'b1;
`else
    localparam logic IRQ = 1'b0;
`endif
    localparam int H = 8, V = 4, N = H * V, AW = 19;

    logic          clk = 1'b0, rst = 1'b1;
    logic [2:0]    addr = '0;
    logic          wr_en = 1'b0, rd_en = 1'b0, sof = 1'b0, pv = 1'b0, keyed = 1'b0;
    logic [31:0]   wdata = '0, rdata, r;
    logic [9:0]    thr;
    logic          key_en, irq;
    logic [AW-1:0] bg;
    int            n_tests = 0, n_fail = 0;

    typedef struct {
        logic [2:0]  a;
        logic        w;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[15];

    chroma_key_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DEFAULT_THR(10'h1FF)) dut (
        .iCLK27(clk), .iRST(rst), .iAddr(addr), .iWrite(wr_en), .iWriteData(wdata),
        .iRead(rd_en), .oReadData(rdata), .iSOF(sof), .iPixValid(pv), .iIsKeyed(keyed),
        .oThreshold(thr), .oKeyEn(key_en), .oBgAddr(bg), .oIrq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=0x%0h exp=0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        addr = a; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        d = rdata;
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    task automatic pix(input logic k);
        pv = 1'b1; keyed = k;
        tick();
        pv = 1'b0; keyed = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{3'd0, 1'b0, 32'h0, 32'h0};
        vecs[1]  = '{3'd1, 1'b0, 32'h0, 32'h1FF};
        vecs[2]  = '{3'd2, 1'b0, 32'h0, 32'h0};
        vecs[3]  = '{3'd3, 1'b0, 32'h0, 32'h0};
        vecs[4]  = '{3'd4, 1'b0, 32'h0, 32'h0};
        vecs[5]  = '{3'd5, 1'b0, 32'h0, 32'h0};
        vecs[6]  = '{3'd6, 1'b0, 32'h0, 32'h0};
        vecs[7]  = '{3'd7, 1'b0, 32'h0, 32'h0};
        vecs[8]  = '{3'd1, 1'b1, 32'hFFFF_F180, 32'h180};
        vecs[9]  = '{3'd2, 1'b1, 32'hFFFF_1000, 32'h0007_1000};
        vecs[10] = '{3'd6, 1'b1, 32'h0000_DEAD, 32'h0};
        vecs[11] = '{3'd7, 1'b1, 32'h0000_BEEF, 32'h0};
        vecs[12] = '{3'd4, 1'b1, 32'h0000_FFFF, 32'h0};
        vecs[13] = '{3'd5, 1'b1, 32'h0000_1234, 32'h0};
        vecs[14] = '{3'd3, 1'b1, 32'hFFFF_FFFF, 32'h0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_thr", 32'(thr), 32'h1FF);
        chk("rst_keyen", 32'(key_en), 32'h0);
        chk("rst_bg", 32'(bg), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rdata", rdata, 32'h0);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].w) wr(vecs[i].a, vecs[i].d);
            rd(vecs[i].a, r);
            chk($sformatf("vec%0d_reg%0d", i, vecs[i].a), r, vecs[i].exp);
        end

        wr(3'd2, 32'h1000);
        wr(3'd0, 32'h3);
        tick();
        chk("armed_keyen", 32'(key_en), 32'h0);
        chk("armed_thr", 32'(thr), 32'h1FF);
        rd(3'd0, r);
        chk("ctrl_rb", r, IRQ ? 32'h3 : 32'h1);
        pulse_sof();
        chk("sof1_thr", 32'(thr), 32'h180);
        chk("sof1_keyen", 32'(key_en), 32'h1);

        for (int i = 0; i < N; i++) begin
            chk($sformatf("f1_bg%0d", i), 32'(bg), 32'h1000 + 32'(i));
            pix(i % 4 == 3);
            if (i % 5 == 4) tick();
        end
        rd(3'd3, r);
        chk("f1_status", r, 32'h1);

        pulse_sof();
        chk("f1_irq", 32'(irq), 32'(IRQ));
        chk("f2_bg0", 32'(bg), 32'h1000);
        rd(3'd4, r);
        chk("f1_keycount", r, 32'd8);
        rd(3'd5, r);
        chk("f1_framecount", r, 32'd1);
        rd(3'd3, r);
        chk("f1_pend", r, IRQ ? 32'h3 : 32'h1);
        wr(3'd3, 32'h2);
        chk("w1c_irq", 32'(irq), 32'h0);
        rd(3'd3, r);
        chk("w1c_status", r, 32'h1);

        for (int i = 0; i <= N; i++) pix(1'b0);
        chk("ovr_bg_hold", 32'(bg), 32'h1000 + 32'(N));
        rd(3'd3, r);
        chk("ovr_status", r, 32'h5);
        wr(3'd3, 32'h4);
        rd(3'd3, r);
        chk("ovr_clear", r, 32'h1);

        addr = 3'd1; wdata = 32'h100; wr_en = 1'b1; sof = 1'b1;
        tick();
        wr_en = 1'b0; sof = 1'b0;
        chk("thr_sof_old", 32'(thr), 32'h180);
        rd(3'd1, r);
        chk("thr_live_new", r, 32'h100);

        addr = 3'd3; wdata = 32'h2; wr_en = 1'b1; sof = 1'b1; pv = 1'b1; keyed = 1'b1;
        tick();
        wr_en = 1'b0; sof = 1'b0; pv = 1'b0; keyed = 1'b0;
        chk("thr_next_frame", 32'(thr), 32'h100);
        chk("sof_pix_bg", 32'(bg), 32'h1000);
        chk("setwins_irq", 32'(irq), 32'(IRQ));
        rd(3'd3, r);
        chk("setwins_status", r, IRQ ? 32'h3 : 32'h1);
        rd(3'd5, r);
        chk("fc3", r, 32'd3);

        pix(1'b1);
        pix(1'b1);
        wr(3'd0, 32'h2);
        pix(1'b1);
        chk("dis_keyen_hold", 32'(key_en), 32'h1);
        chk("f4_bg", 32'(bg), 32'h1003);
        pulse_sof();
        chk("dis_keyen_off", 32'(key_en), 32'h0);
        rd(3'd4, r);
        chk("f4_keycount", r, 32'd3);
        rd(3'd5, r);
        chk("fc4", r, 32'd4);
        rd(3'd3, r);
        chk("idle_status", r, IRQ ? 32'h2 : 32'h0);

        wr(3'd0, 32'h3);
        tick();
        pulse_sof();
        chk("rearm_keyen", 32'(key_en), 32'h1);
        pix(1'b1);
        pix(1'b0);
        chk("pre_rst_irq", 32'(irq), 32'(IRQ));
        #3 rst = 1'b1;
        #1;
        chk("arst_keyen", 32'(key_en), 32'h0);
        chk("arst_thr", 32'(thr), 32'h1FF);
        chk("arst_bg", 32'(bg), 32'h0);
        chk("arst_irq", 32'(irq), 32'h0);
        chk("arst_rdata", rdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        rd(3'd5, r);
        chk("arst_fc", r, 32'h0);
        rd(3'd4, r);
        chk("arst_kc", r, 32'h0);
        rd(3'd0, r);
        chk("arst_ctrl", r, 32'h0);

        addr = 3'd1; wdata = 32'h55; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("rw_same_pre", rdata, 32'h1FF);
        rd(3'd1, r);
        chk("rw_same_post", r, 32'h55);
        chk("no_irq_end", 32'(irq), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/chroma_key_ctrl.md
# chroma_key_ctrl

Frame-synchronous controller for the chroma-key keyer in the Nios video path. Holds the keyer threshold and enable behind a small register slave, so the processor can change settings at any time. Applies those settings to the keyer only at start-of-frame, so each frame is keyed with one consistent setting. Also generates the linear background-memory read address for each pixel, counts keyed pixels per frame, and raises an end-of-frame interrupt.

## Interface
Parameters:
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- ADDR_W, 19: background address width.
- DEFAULT_THR, 10'h1FF: reset threshold.

Ports:
- iCLK27  in  1  pixel/system clock; all logic on rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iAddr  in  3  register word address.
- iWrite  in  1  write strobe, one cycle per access.
- iWriteData  in  32  write data.
- iRead  in  1  read strobe.
- oReadData  out  32  read data, valid one cycle after iRead.
- iSOF  in  1  start-of-frame pulse, one cycle, before the first pixel of the frame.
- iPixValid  in  1  active pixel present this cycle.
- iIsKeyed  in  1  keyer compare result for the current pixel; sampled only when iPixValid=1.
- oThreshold  out  10  threshold applied to the keyer.
- oKeyEn  out  1  keyer substitution enable.
- oBgAddr  out  ADDR_W  background pixel address for the current pixel.
- oIrq  out  1  end-of-frame interrupt, level.

## Operation
Registers (live = written by the processor; shadow = what drives the keyer):
- 0 CTRL, R/W: bit0 ENABLE, bit1 IRQ_EN.
- 1 THRESHOLD, R/W: bits [9:0].
- 2 BG_BASE, R/W: bits [ADDR_W-1:0].
- 3 STATUS:
  - bit0 ACTIVE, RO.
  - bit1 IRQ_PEND, write 1 to clear.
  - bit2 OVERRUN, write 1 to clear.
- 4 KEY_COUNT, RO: keyed-pixel count of the last completed frame, 20 bits.
- 5 FRAME_COUNT, RO: 16 bits, wraps.
- 6 and 7: read 0, writes ignored.

FSM states:
- IDLE:
  - oKeyEn=0.
  - Go to ARMED when live ENABLE=1.
- ARMED:
  - oKeyEn=0.
  - On iSOF: copy live THRESHOLD/BG_BASE into shadow, go to ACTIVE.
  - If live ENABLE returns to 0 before iSOF: return to IDLE.
- ACTIVE:
  - oKeyEn=1.
  - On iSOF with live ENABLE=1: close the frame, re-copy shadow, stay in ACTIVE.
  - On iSOF with live ENABLE=0: close the frame, go to IDLE (oKeyEn=0 from the next cycle).

Closing a frame (iSOF while ACTIVE):
- KEY_COUNT ← running count.
- FRAME_COUNT increments.
- IRQ_PEND set.
- Running count and address counter reset.

Address generator:
- Pixel counter resets to 0 on iSOF.
- Counter increments on each iPixValid while below H_ACTIVE*V_ACTIVE.
- oBgAddr = shadow BG_BASE + pixel counter, modulo 2^ADDR_W.
- A valid pixel arriving once the counter equals H_ACTIVE*V_ACTIVE sets OVERRUN; the counter holds.

Keyed count:
- Increments on iPixValid & iIsKeyed while ACTIVE.
- Saturates at 2^20-1.

## Timing
- Reset values:
  - oThreshold=DEFAULT_THR, oKeyEn=0, oBgAddr=0, oIrq=0, oReadData=0.
  - State IDLE, all registers 0 except THRESHOLD=DEFAULT_THR.
- Reset asserted mid-frame: everything returns to reset values immediately. No frame close, no IRQ.
- Shadow copy and state change take effect the cycle after iSOF.
- oBgAddr is registered and addresses the pixel whose iPixValid is high in that cycle. It advances the cycle after each valid pixel.
- Write to THRESHOLD in the same cycle as iSOF: shadow takes the old value; the new value applies from the next frame.
- W1C of IRQ_PEND in the same cycle as a frame close: set wins, IRQ_PEND=1.
- iPixValid in the same cycle as iSOF: the pixel is ignored (not counted, not addressed).
- Read latency is 1 cycle. Simultaneous read and write to the same address returns the pre-write value.
- oIrq = IRQ_PEND & IRQ_EN, registered.

## Configuration
- CHROMA_IRQ_EN defined: IRQ_PEND, IRQ_EN and oIrq are implemented as described above.
- CHROMA_IRQ_EN undefined:
  - oIrq tied 0.
  - CTRL bit1 and STATUS bit1 read 0; writes to them are ignored.
  - All other behaviour is unchanged.

## Test plan
- Reset, then read all 8 addresses → CTRL=0, THRESHOLD=0x1FF, reads 6 and 7 return 0; oKeyEn=0, oBgAddr=0.
- Write THRESHOLD=0x180, BG_BASE=0x1000, ENABLE=1, then pulse iSOF → oThreshold=0x180 and oKeyEn=1 one cycle after iSOF; first valid pixel sees oBgAddr=0x1000, the second 0x1001.
- Stream one 640×480 frame with every 4th pixel keyed, then iSOF → KEY_COUNT=76800, FRAME_COUNT=1, oIrq=1 with IRQ_EN=1 (CHROMA_IRQ_EN defined); W1C of bit1 drops oIrq.
- Send 307201 valid pixels in one frame → OVERRUN=1, oBgAddr holds at BG_BASE+307200.
- Write THRESHOLD=0x100 in the same cycle as iSOF → oThreshold keeps its old value for that frame and becomes 0x100 after the following iSOF.
- Clear ENABLE mid-frame → oKeyEn stays 1 until the next iSOF, then 0; assert iRST mid-frame → all outputs at reset values immediately and no IRQ.
